// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Purpose : Shared types and constants for the 16-bit asynchronous SRAM
//           controller: the access FSM state type, the SRAM bus widths and the
//           default CPU byte address that maps to SRAM halfword 0.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_AW           = 18;
    localparam int SRAM_DW           = 16;
    localparam int ADDR_BASE_DEFAULT = 1024;

endpackage

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
// Purpose : CPU-side load/store handshake between the memory stage (master)
//           and the SRAM controller (slave).
// Signals : rd_en, wr_en, address[31:0], write_data[31:0]  master -> slave
//           read_data[31:0], ready                        slave  -> master
//           addr_err                                      slave  -> master,
//           present only when SRAM_RANGE_CHECK_EN is defined
// -----------------------------------------------------------------------------
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

`ifdef SRAM_RANGE_CHECK_EN
    logic        addr_err;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready, addr_err
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready, addr_err
    );
`else
    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
`endif

endinterface

// File: rtl/sram_phase_timer.sv
// -----------------------------------------------------------------------------
// sram_phase_timer
// Purpose : Times one SRAM phase (WAIT_CYCLES strobe cycles + 1 hold/sample
//           cycle). A down-counter is loaded with WAIT_CYCLES on the edge that
//           enters the phase and counts to zero; zero marks the last cycle.
// Ports   : clk              system clock
//           rst              synchronous active-high reset
//           load_i           high in the cycle before a phase starts
//           strobe_active_o  high during the first WAIT_CYCLES cycles
//           phase_last_o     high on the final cycle of the phase
// -----------------------------------------------------------------------------
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic strobe_active_o,
    output logic phase_last_o
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(WAIT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign strobe_active_o = (count_q != '0);
    assign phase_last_o    = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Purpose : CPU-side initiator for a 16-bit asynchronous SRAM. Each 32-bit
//           load/store becomes two halfword accesses (low half, then high
//           half); ready holds the pipeline until the access completes.
// Ports   : clk        system clock, all logic on posedge
//           rst        synchronous active-high reset
//           bus        sram_controller_if.slave (rd_en, wr_en, address,
//                      write_data, read_data, ready [, addr_err])
//           SRAM_DQ    SRAM data bus, driven only during write phases
//           SRAM_ADDR  SRAM halfword address
//           SRAM_WE_N  SRAM write enable, active low
// Params  : ADDR_BASE    byte address mapped to SRAM halfword 0
//           WAIT_CYCLES  strobe cycles per phase before the sample/hold cycle
// Macro   : SRAM_RANGE_CHECK_EN - reject addresses outside the SRAM window
//           with a one-cycle addr_err pulse instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a request; ready = ~(rd_en | wr_en)
// LOW   | access to the low halfword (data[15:0])
// HIGH  | access to the high halfword (data[31:16])
// DONE  | one-cycle completion, ready = 1, requests ignored
// -----------------------------------------------------------------------------
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    state_t              state_q, state_d;
    logic [SRAM_AW-2:0]  word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [SRAM_DW-1:0]  lo_q, lo_d;
    logic [31:0]         rdata_q, rdata_d;

    logic        req;
    logic        ready;
    logic        load;
    logic        strobe_active;
    logic        phase_last;
    logic        in_phase;
    logic        drive;
    logic        high_half;
    logic [31:0] eff_full;
    logic        unused_addr_bits;

    assign req      = bus.rd_en | bus.wr_en;
    assign eff_full = bus.address - 32'(ADDR_BASE);

    // Word alignment makes the two lowest offset bits meaningless; the upper
    // bits only matter for the optional range check.
    assign unused_addr_bits = ^{eff_full[31:19], eff_full[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic out_of_range;

    assign out_of_range = (bus.address < 32'(ADDR_BASE)) || (eff_full[31:19] != '0);
    assign bus.addr_err = err_q;
`endif

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .load_i          (load),
        .strobe_active_o (strobe_active),
        .phase_last_o    (phase_last)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        write_d = write_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        ready   = 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                ready = ~req;
`ifdef SRAM_RANGE_CHECK_EN
                // The error cycle behaves like DONE: ready high, request
                // ignored, so a still-asserted request cannot re-trigger.
                if (err_q) begin
                    ready = 1'b1;
                end else if (req && out_of_range) begin
                    err_d = 1'b1;
                end else
`endif
                if (req) begin
                    word_d  = eff_full[18:2];
                    wdata_d = bus.write_data;
                    write_d = bus.wr_en;
                    load    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                ready = 1'b0;
                if (phase_last) begin
                    if (!write_q) begin
                        lo_d = SRAM_DQ;
                    end
                    load    = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                ready = 1'b0;
                if (phase_last) begin
                    if (!write_q) begin
                        rdata_d = {SRAM_DQ, lo_q};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
`ifdef SRAM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
`ifdef SRAM_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Bus outputs decode from registered state only, so a reset edge releases
    // DQ and raises WE_N on that same edge.
    assign in_phase  = (state_q == LOW) || (state_q == HIGH);
    assign high_half = (state_q == HIGH);
    assign drive     = write_q && in_phase;

    assign SRAM_WE_N = ~(drive && strobe_active);
    assign SRAM_ADDR = {word_q, high_half};
    assign SRAM_DQ   = drive ? (high_half ? wdata_q[31:16] : wdata_q[15:0]) : 'z;

    assign bus.ready     = ready;
    assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int W    = 1;
    localparam int BASE = 1024;
    localparam int T    = 2 * W + 3;   // DONE cycle index, request cycle = 0
`ifdef SRAM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus();
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    sram_controller #(
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- SRAM device model ----------------
    logic [15:0] mem [0:1023];
    int          we_cnt [0:1023];
    int          we_total = 0;
    bit          sram_preloaded = 0;
    logic        sram_oe  = 1'b0;
    logic        probe_oe = 1'b0;
    logic [15:0] sram_out;

    assign sram_out = probe_oe ? 16'h5A5A : mem[SRAM_ADDR[9:0]];
    assign SRAM_DQ  = (sram_oe || probe_oe) ? sram_out : 16'bz;

    always @(posedge clk) begin
        if (!sram_preloaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i]    = 16'h3C00 + 16'(i) * 16'h0101;
                we_cnt[i] = 0;
            end
            sram_preloaded = 1;
        end
        if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[9:0]] = SRAM_DQ;
            we_cnt[SRAM_ADDR[9:0]]++;
            we_total++;
        end
    end

    // ---------------- behavioural model ----------------
    // k: -1 while idle, otherwise cycle index within the current access.
    int          k = -1;
    bit          m_write = 0;
    logic [31:0] m_data  = '0;
    int          m_eff   = 0;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 0;
    logic [15:0] m_mem [0:1023];
    bit          m_preloaded = 0;
    bit          chk_en = 0;
    int          err_pulses = 0;

    always @(posedge clk) begin : model
        logic [31:0] diff;
        int          hw;
        if (!m_preloaded) begin
            for (int i = 0; i < 1024; i++) m_mem[i] = 16'h3C00 + 16'(i) * 16'h0101;
            m_preloaded = 1;
        end
        if (rst) begin
            k       = -1;
            m_rdata = '0;
            m_err   = 0;
        end else if (k < 0) begin
            if (m_err) begin
                m_err = 0;
            end else if (bus.rd_en || bus.wr_en) begin
                diff = bus.address - 32'(BASE);
                if (RANGE_CHK && ((bus.address < 32'(BASE)) || (diff >= 32'h0008_0000))) begin
                    m_err = 1;
                end else begin
                    m_write = bus.wr_en;
                    m_data  = bus.write_data;
                    m_eff   = int'(diff % 32'h0008_0000);
                    k       = 1;
                end
            end
        end else if (k == T) begin
            k = -1;
        end else begin
            k++;
            if (k == T) begin
                hw = m_eff / 2;
                if (m_write) begin
                    m_mem[hw % 1024]       = m_data[15:0];
                    m_mem[(hw + 1) % 1024] = m_data[31:16];
                end else begin
                    m_rdata = {m_mem[(hw + 1) % 1024], m_mem[hw % 1024]};
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit   req, in_ph, hi_ph, exp_ready, exp_we_n;
        int   off;
        if (chk_en) begin
            req   = bus.rd_en || bus.wr_en;
            in_ph = (k >= 1) && (k <= 2 * W + 2);
            hi_ph = (k >= W + 2);
            off   = hi_ph ? (k - W - 2) : (k - 1);
            if (k < 0) exp_ready = m_err ? 1'b1 : !req;
            else       exp_ready = (k == T);
            exp_we_n = !(m_write && in_ph && (off < W));
            chk("ready", 32'(bus.ready), 32'(exp_ready));
            chk("we_n", 32'(SRAM_WE_N), 32'(exp_we_n));
            chk("read_data", bus.read_data, m_rdata);
            if (in_ph) chk("sram_addr", 32'(SRAM_ADDR), 32'(m_eff / 2 + (hi_ph ? 1 : 0)));
            if (in_ph && m_write)
                chk("dq_write", 32'(SRAM_DQ), 32'(hi_ph ? m_data[31:16] : m_data[15:0]));
`ifdef SRAM_RANGE_CHECK_EN
            chk("addr_err", 32'(bus.addr_err), 32'(m_err));
            if (bus.addr_err) err_pulses++;
`endif
            sram_oe = in_ph && !m_write;
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_released(input string name);
        probe_oe = 1'b1;
        #1;
        chk(name, 32'(SRAM_DQ), 32'h5A5A);
        probe_oe = 1'b0;
        #1;
    endtask

    task automatic access(input bit skip_wait, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, output int lowcnt);
        bit seen_hi;
        if (!skip_wait) begin
            @(posedge clk);
            #1;
        end
        bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
        lowcnt  = 0;
        seen_hi = 0;
        for (int n = 0; n < 50 && !seen_hi; n++) begin
            @(negedge clk);
            if (bus.ready) seen_hi = 1;
            else           lowcnt++;
            if (!seen_hi && n == 1) begin
                bus.address    = ~a;
                bus.write_data = ~d;
            end
        end
        chk("access_timeout", 32'(seen_hi), 32'd1);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int lc;
        int we0;
`ifdef SRAM_RANGE_CHECK_EN
        int err0;
`endif
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1. reset state
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk_released("rst_dq_released");

        // 2. store 0xDEADBEEF at 1028
        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lc);
        chk("wr_ready_low_cycles", 32'(lc), 32'd5);
        chk("wr_mem2", 32'(mem[2]), 32'hBEEF);
        chk("wr_mem3", 32'(mem[3]), 32'hDEAD);
        chk("wr_we_pulses_lo", 32'(we_cnt[2]), 32'd1);
        chk("wr_we_pulses_hi", 32'(we_cnt[3]), 32'd1);

        // 3. load back, issued in the IDLE cycle right after DONE
        access(1, 1'b1, 1'b0, 32'd1028, 32'h0, lc);
        chk("rd_ready_low_cycles", 32'(lc), 32'd5);
        chk("rd_data", bus.read_data, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("rd_data_held", bus.read_data, 32'hDEADBEEF);

        // 4. rd_en and wr_en together: write only
        access(0, 1'b1, 1'b1, 32'd1032, 32'h12345678, lc);
        chk("both_mem4", 32'(mem[4]), 32'h5678);
        chk("both_mem5", 32'(mem[5]), 32'h1234);
        chk("both_read_data_kept", bus.read_data, 32'hDEADBEEF);
        @(negedge clk);
        chk_released("idle_dq_released");

        // load from preloaded halfwords 8/9
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, lc);
        chk("rd_preload", bus.read_data, 32'h45094408);

        // 5. reset in the second cycle of HIGH of a write
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hA5A5C3C3;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; bus.wr_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_read_data", bus.read_data, 32'h0);
        chk_released("abort_dq_released");
        @(posedge clk); #1;
        rst = 1'b0;

        // address beyond the SRAM window
        access(0, 1'b0, 1'b1, 32'(BASE + 524288 + 24), 32'hCAFEF00D, lc);
        access(0, 1'b1, 1'b0, 32'd1048, 32'h0, lc);
`ifdef SRAM_RANGE_CHECK_EN
        chk("oor_no_write", bus.read_data, 32'h490D480C);

        // 6. below ADDR_BASE
        we0  = we_total;
        err0 = err_pulses;
        access(0, 1'b1, 1'b0, 32'd1020, 32'h0, lc);
        chk("err_ready_low_cycles", 32'(lc), 32'd1);
        repeat (2) @(negedge clk);
        chk("err_pulse_count", 32'(err_pulses - err0), 32'd1);
        chk("err_no_strobe", 32'(we_total - we0), 32'd0);
        chk("err_read_data_kept", bus.read_data, 32'h490D480C);
`else
        chk("wrap_mem12", 32'(mem[12]), 32'hF00D);
        chk("wrap_mem13", 32'(mem[13]), 32'hCAFE);
        chk("wrap_read", bus.read_data, 32'hCAFEF00D);
        we0 = we_total;
        repeat (3) @(negedge clk);
        chk("idle_no_strobe", 32'(we_total - we0), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
